// File: rtl/my_serial_addsub_if.sv
// Handshake/operand bundle for the digit-serial add/subtract unit.
// master drives start/sub/A/B/C0; slave returns busy/done/Res/C/V/Z.
interface my_serial_addsub_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Res;
   logic             C;
   logic             V;
   logic             Z;

   modport master (
      output start, sub, A, B, C0,
      input  busy, done, Res, C, V, Z
   );

   modport slave (
      input  start, sub, A, B, C0,
      output busy, done, Res, C, V, Z
   );
endinterface

// File: rtl/my_serial_addsub.sv
// Digit-serial 2's-complement add/subtract, DIGIT bits per clock,
// N = WIDTH/DIGIT cycles per op, start/busy/done handshake, C/V/Z flags.
// Ports: clk, reset (async, active-high), bus (my_serial_addsub_if.slave):
//   start/sub/A/B/C0 in; busy/done/Res/C/V/Z out.
// Option: define ADDSUB_SAT_EN to saturate Res on signed overflow.
module my_serial_addsub #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input logic               clk,
   input logic               reset,
   my_serial_addsub_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_fin;
   logic [CW-1:0]    cnt_q;
   logic             cy_q;
   logic             sub_q;
   logic             c_q;
   logic             v_q;
   logic             z_q;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] s_dig;
   logic             d_cout;
   logic             msb_cin;
   logic             ovf;
   logic             last;
   logic             accept;
   logic             busy_o;
   logic             done_o;
   int               base;

   assign last   = (cnt_q == CW'(N - 1));
   assign accept = bus.start && (state != RUN);

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.start) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = bus.start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      unique case (state)
         RUN:     busy_o = 1'b1;
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   // One digit of the ripple, plus the accumulator image after this digit.
   always_comb begin
      base    = int'(cnt_q) * DIGIT;
      a_dig   = a_q[base +: DIGIT];
      b_dig   = b_q[base +: DIGIT];
      {d_cout, s_dig} = {1'b0, a_dig} + {1'b0, b_dig}
                      + {{DIGIT{1'b0}}, cy_q};
      // Sum bit = a ^ b ^ cin, so the MSB carry-in falls out directly.
      msb_cin = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
      ovf     = msb_cin ^ d_cout;
      acc_nxt = acc_q;
      acc_nxt[base +: DIGIT] = s_dig;
   end

`ifdef ADDSUB_SAT_EN
   // Overflow only occurs when A and B' share a sign, so A's MSB
   // tells which rail the true result lies beyond.
   always_comb begin
      res_fin = acc_nxt;
      if (ovf) begin
         res_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign res_fin = acc_nxt;
`endif

   // Datapath: operand latch, digit walk, result/flag commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         cy_q  <= 1'b0;
         sub_q <= 1'b0;
         res_q <= '0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
         z_q   <= 1'b0;
      end else if (accept) begin
         // Subtract as A + ~B + ~C0 so one adder serves both modes.
         a_q   <= bus.A;
         b_q   <= bus.sub ? ~bus.B : bus.B;
         cy_q  <= bus.sub ? ~bus.C0 : bus.C0;
         sub_q <= bus.sub;
         cnt_q <= '0;
         acc_q <= '0;
      end else if (state == RUN) begin
         acc_q <= acc_nxt;
         cy_q  <= d_cout;
         cnt_q <= cnt_q + CW'(1);
         if (last) begin
            res_q <= res_fin;
            c_q   <= sub_q ? ~d_cout : d_cout;
            v_q   <= ovf;
            z_q   <= (res_fin == '0);
         end
      end
   end

   assign bus.busy = busy_o;
   assign bus.done = done_o;
   assign bus.Res  = res_q;
   assign bus.C    = c_q;
   assign bus.V    = v_q;
   assign bus.Z    = z_q;

endmodule
